matrix_stream_alu: RTL and testbench
====================================

MATRIX_STREAM_ALU -- requirements
Module: matrix_stream_alu

Interface
REQ-001 SHALL have parameter ELEM_W, default 8: signed element width.
REQ-002 SHALL have parameter MAX_DIM, default 5: maximum rows/cols per operand.
REQ-003 SHALL have parameter ACC_W, default 24: signed accumulator width, at least 2*ELEM_W+4.
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: single-cycle request, sampled in IDLE only.
REQ-007 SHALL have port abort  in  1: cancels any operation in progress.
REQ-008 SHALL have port op_code  in  op_code_t: operation select (ADD, SUB, SCALAR_MUL, TRANSPOSE, MAT_MUL).
REQ-009 SHALL have ports a_rows, a_cols, b_rows, b_cols  in  $clog2(MAX_DIM+1) each: operand dimensions.
REQ-010 SHALL have ports mat_a, mat_b  in  MAX_DIM*MAX_DIM*ELEM_W each: row-major packed operands, held stable while busy.
REQ-011 SHALL have port scalar  in  ELEM_W: scalar multiplier.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1, out_data out ELEM_W, out_row/out_col out $clog2(MAX_DIM), out_last out 1: result element stream.
REQ-013 SHALL have ports busy out 1, done out 1 (pulse), error_flag out 1, cycle_cnt out 32.

Function
REQ-014 SHALL implement states IDLE, CALC, OUT, DONE.
REQ-015 Transition IDLE->CALC SHALL occur on start with legal dims; otherwise IDLE->DONE with error_flag=1.
- Illegal: any dim 0 or >MAX_DIM; ADD/SUB shape mismatch; MAT_MUL a_cols!=b_rows; unknown op.
REQ-016 Result shape SHALL be:
- a_rows x a_cols for ADD/SUB/SCALAR_MUL;
- a_cols x a_rows for TRANSPOSE;
- a_rows x b_cols for MAT_MUL.
REQ-017 CALC SHALL spend 1 cycle per element for elementwise ops and 1 cycle per k (a_cols cycles) for MAT_MUL, using one shared multiplier.
REQ-018 CALC->OUT SHALL occur when the element is complete; OUT SHALL hold out_valid=1 with stable data until out_valid&&out_ready.
REQ-019 On handshake SHALL advance column-major-inner (col then row) and return to CALC, or go to DONE when out_last was set.
REQ-020 out_last SHALL be 1 only for element (rows-1, cols-1).
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; start is not required to fall.
REQ-022 abort SHALL force IDLE on the next edge from any state; out_valid and busy drop, done is not pulsed, error_flag is cleared.
REQ-023 abort and start in the same IDLE cycle: abort SHALL win, and no operation starts.
REQ-024 busy SHALL be 1 in CALC and OUT.
REQ-025 cycle_cnt SHALL clear on accepted start, increment every CALC/OUT cycle, and hold after done.
REQ-026 Products and sums SHALL be computed at ACC_W signed width; the accumulator clears per element.
REQ-027 error_flag SHALL hold until the next accepted start or abort.

Reset
REQ-028 rst_n low SHALL force state IDLE, counters/accumulator 0, and all outputs 0 (out_valid, done, busy, error_flag, out_data, out_row, out_col, out_last, cycle_cnt).

Configuration
REQ-029 With MATRIX_STREAM_ALU_SAT_EN defined, results SHALL clamp to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
REQ-030 Without MATRIX_STREAM_ALU_SAT_EN, results SHALL be the low ELEM_W bits (two's-complement wrap).

Structure
REQ-031 op_code_t, including new code OP_SUB, SHALL reside in project_pkg, along with default ELEM_W/MAX_DIM constants.
REQ-032 Saturate/truncate logic SHALL be a sub-module, elem_narrow, parametrised by ACC_W/ELEM_W.

Verification
REQ-033 Scenario: ADD 2x2 [1,2;3,4]+[10,20;30,40], out_ready=1 -> stream 11,22,33,44; out_last on 44; done 1 cycle later.
REQ-034 Scenario: MAT_MUL 2x3 [1,2,3;4,5,6] * 3x2 [7,8;9,10;11,12] with SAT_EN -> 58,64,127,127; with SAT_EN undefined -> 58,64,-117,-102; cycle_cnt=16 (12 CALC + 4 OUT).
REQ-035 Scenario: ADD with a_rows=2, b_rows=3 -> no out_valid, error_flag=1, done pulse 1 cycle after start.
REQ-036 Scenario: TRANSPOSE 2x3 [1..6] with out_ready low 5 cycles at element 2 -> out_data=4 held stable; stream order 1,4,2,5,3,6.
REQ-037 Scenario: SCALAR_MUL 3x3 by -128 of value -1, abort asserted mid-OUT -> IDLE next cycle, no done; a following start runs normally.
REQ-038 Scenario: rst_n asserted mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/project_pkg.sv
// Shared types and default sizing for the matrix stream ALU.
//   op_code_t : operation select carried on the op_code port
//   state_t   : matrix_stream_alu controller states
//   DEF_*     : default element width, matrix dimension and accumulator width
package project_pkg;

    localparam int unsigned DEF_ELEM_W  = 8;
    localparam int unsigned DEF_MAX_DIM = 5;
    localparam int unsigned DEF_ACC_W   = 24;

    typedef enum logic [2:0] {
        OP_ADD        = 3'd0,
        OP_SUB        = 3'd1,
        OP_SCALAR_MUL = 3'd2,
        OP_TRANSPOSE  = 3'd3,
        OP_MAT_MUL    = 3'd4
    } op_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/elem_narrow.sv
// Narrows a signed ACC_W accumulator value to an ELEM_W result element.
// Build option: MATRIX_STREAM_ALU_SAT_EN defined -> clamp to the signed ELEM_W
// range; undefined -> keep the low ELEM_W bits (two's-complement wrap).
//   acc_i  : signed accumulator value
//   elem_c : narrowed element (combinational)
module elem_narrow #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned ELEM_W = 8
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [ELEM_W-1:0] elem_c
);

`ifdef MATRIX_STREAM_ALU_SAT_EN
    // Value fits when every bit from the element sign bit upward agrees.
    logic [ACC_W-ELEM_W:0] top_bits;
    assign top_bits = acc_i[ACC_W-1:ELEM_W-1];

    always_comb begin
        elem_c = acc_i[ELEM_W-1:0];
        if (!((&top_bits) || (~|top_bits))) begin
            elem_c = {acc_i[ACC_W-1], {(ELEM_W-1){~acc_i[ACC_W-1]}}};
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^acc_i[ACC_W-1:ELEM_W];
    assign elem_c    = acc_i[ELEM_W-1:0];
`endif

endmodule

// File: rtl/matrix_stream_alu.sv
// Streaming matrix ALU: ADD, SUB, SCALAR_MUL, TRANSPOSE and MAT_MUL on small
// signed matrices, one shared multiplier, results streamed out element by
// element (row by row, column inner) over a valid/ready handshake.
// Operands are row-major with a fixed stride of MAX_DIM: element (r,c) sits at
// bits [(r*MAX_DIM+c)*ELEM_W +: ELEM_W].
// Build option: MATRIX_STREAM_ALU_SAT_EN selects saturating narrowing.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   start, abort                   : request / cancel
//   op_code, a_/b_rows/cols        : operation and operand shapes
//   mat_a, mat_b, scalar           : operands (stable while busy)
//   out_valid/ready/data/row/col/last : result stream
//   busy, done, error_flag, cycle_cnt : status
module matrix_stream_alu
    import project_pkg::*;
#(
    parameter int unsigned ELEM_W  = DEF_ELEM_W,
    parameter int unsigned MAX_DIM = DEF_MAX_DIM,
    parameter int unsigned ACC_W   = DEF_ACC_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  op_code_t                          op_code,
    input  logic [$clog2(MAX_DIM+1)-1:0]      a_rows,
    input  logic [$clog2(MAX_DIM+1)-1:0]      a_cols,
    input  logic [$clog2(MAX_DIM+1)-1:0]      b_rows,
    input  logic [$clog2(MAX_DIM+1)-1:0]      b_cols,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_a,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_b,
    input  logic [ELEM_W-1:0]                 scalar,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ELEM_W-1:0]                 out_data,
    output logic [$clog2(MAX_DIM)-1:0]        out_row,
    output logic [$clog2(MAX_DIM)-1:0]        out_col,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              error_flag,
    output logic [31:0]                       cycle_cnt
);

    localparam int unsigned DIM_W = $clog2(MAX_DIM+1);
    localparam int unsigned IDX_W = $clog2(MAX_DIM);

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

    state_t                    state_q, state_d;
    op_code_t                  op_q, op_d;
    logic [IDX_W-1:0]          row_q, row_d, col_q, col_d, k_q, k_d;
    logic [IDX_W-1:0]          row_last_q, row_last_d, col_last_q, col_last_d;
    logic [IDX_W-1:0]          k_last_q, k_last_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ELEM_W-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                      busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]               cycle_cnt_q, cycle_cnt_d;

    logic                      legal_c;
    logic [DIM_W-1:0]          res_rows_c, res_cols_c;
    logic signed [ELEM_W-1:0]  a_arr [MAX_DIM][MAX_DIM];
    logic signed [ELEM_W-1:0]  b_arr [MAX_DIM][MAX_DIM];
    logic signed [ELEM_W-1:0]  ea_c, eb_c, mul_rhs_c;
    logic signed [ACC_W-1:0]   product_c, term_c, sum_c;
    logic [ELEM_W-1:0]         narrow_c;

    // Operand legality and result shape for the request on the inputs.
    always_comb begin
        legal_c    = dim_ok(a_rows) && dim_ok(a_cols);
        res_rows_c = a_rows;
        res_cols_c = a_cols;
        case (op_code)
            OP_ADD, OP_SUB: legal_c = legal_c && dim_ok(b_rows) && dim_ok(b_cols)
                                      && (a_rows == b_rows) && (a_cols == b_cols);
            OP_SCALAR_MUL: begin end
            OP_TRANSPOSE: begin
                res_rows_c = a_cols;
                res_cols_c = a_rows;
            end
            OP_MAT_MUL: begin
                legal_c    = legal_c && dim_ok(b_rows) && dim_ok(b_cols) && (a_cols == b_rows);
                res_cols_c = b_cols;
            end
            default: legal_c = 1'b0;
        endcase
    end

    // Unpack the flat operand buses into 2-D element arrays.
    always_comb begin
        for (int r = 0; r < int'(MAX_DIM); r++) begin
            for (int c = 0; c < int'(MAX_DIM); c++) begin
                a_arr[r][c] = mat_a[(r*int'(MAX_DIM)+c)*int'(ELEM_W) +: ELEM_W];
                b_arr[r][c] = mat_b[(r*int'(MAX_DIM)+c)*int'(ELEM_W) +: ELEM_W];
            end
        end
    end

    // Per-cycle datapath: operand select, shared multiplier, accumulate.
    always_comb begin
        ea_c = a_arr[row_q][col_q];
        eb_c = b_arr[row_q][col_q];
        case (op_q)
            OP_TRANSPOSE: ea_c = a_arr[col_q][row_q];
            OP_MAT_MUL: begin
                ea_c = a_arr[row_q][k_q];
                eb_c = b_arr[k_q][col_q];
            end
            default: begin end
        endcase
        mul_rhs_c = (op_q == OP_SCALAR_MUL) ? $signed(scalar) : eb_c;
        product_c = ACC_W'(ea_c) * ACC_W'(mul_rhs_c);
        case (op_q)
            OP_ADD:       term_c = ACC_W'(ea_c) + ACC_W'(eb_c);
            OP_SUB:       term_c = ACC_W'(ea_c) - ACC_W'(eb_c);
            OP_TRANSPOSE: term_c = ACC_W'(ea_c);
            default:      term_c = product_c;
        endcase
        // acc_q is zero at the first k of every element.
        sum_c = acc_q + term_c;
    end

    elem_narrow #(
        .ACC_W  (ACC_W),
        .ELEM_W (ELEM_W)
    ) u_narrow (
        .acc_i  (sum_c),
        .elem_c (narrow_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        k_d         = k_q;
        row_last_d  = row_last_q;
        col_last_d  = col_last_q;
        k_last_d    = k_last_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        error_d     = error_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cycle_cnt_d = '0;
                    if (legal_c) begin
                        state_d    = ST_CALC;
                        error_d    = 1'b0;
                        op_d       = op_code;
                        row_d      = '0;
                        col_d      = '0;
                        k_d        = '0;
                        acc_d      = '0;
                        row_last_d = IDX_W'(res_rows_c - DIM_W'(1));
                        col_last_d = IDX_W'(res_cols_c - DIM_W'(1));
                        k_last_d   = (op_code == OP_MAT_MUL) ? IDX_W'(a_cols - DIM_W'(1)) : '0;
                    end else begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if (k_q == k_last_q) begin
                    state_d     = ST_OUT;
                    out_data_d  = narrow_c;
                    out_valid_d = 1'b1;
                    out_last_d  = (row_q == row_last_q) && (col_q == col_last_q);
                    k_d         = '0;
                    acc_d       = '0;
                end else begin
                    acc_d = sum_c;
                    k_d   = k_q + IDX_W'(1);
                end
            end
            ST_OUT: begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        if (col_q == col_last_q) begin
                            col_d = '0;
                            row_d = row_q + IDX_W'(1);
                        end else begin
                            col_d = col_q + IDX_W'(1);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_OUT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            row_last_q  <= '0;
            col_last_q  <= '0;
            k_last_q    <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            k_q         <= k_d;
            row_last_q  <= row_last_d;
            col_last_q  <= col_last_d;
            k_last_q    <= k_last_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error_flag = error_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_matrix_stream_alu.sv
// Directed self-checking bench for matrix_stream_alu (default parameters).
module tb_matrix_stream_alu;
    import project_pkg::*;

    localparam int unsigned ELEM_W  = 8;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned MAT_W   = MAX_DIM*MAX_DIM*ELEM_W;

`ifdef MATRIX_STREAM_ALU_SAT_EN
    localparam int MM_E2 = 127;
    localparam int MM_E3 = 127;
    localparam int SM_E0 = 127;
`else
    localparam int MM_E2 = -117;
    localparam int MM_E3 = -102;
    localparam int SM_E0 = -128;
`endif

    logic             clk, rst_n, start, abort, out_ready;
    op_code_t         op_code;
    logic [2:0]       a_rows, a_cols, b_rows, b_cols;
    logic [MAT_W-1:0] mat_a, mat_b;
    logic [7:0]       scalar;
    logic             out_valid, out_last, busy, done, error_flag;
    logic [7:0]       out_data;
    logic [2:0]       out_row, out_col;
    logic [31:0]      cycle_cnt;

    int n_vec = 0;
    int n_err = 0;

    matrix_stream_alu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_code(op_code),
        .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
        .mat_a(mat_a), .mat_b(mat_b), .scalar(scalar),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done), .error_flag(error_flag), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int r, input int c, input int v);
        mat_a[(r*int'(MAX_DIM)+c)*int'(ELEM_W) +: ELEM_W] = 8'(v);
    endtask

    task automatic set_b(input int r, input int c, input int v);
        mat_b[(r*int'(MAX_DIM)+c)*int'(ELEM_W) +: ELEM_W] = 8'(v);
    endtask

    task automatic do_start(input op_code_t op, input int ar, input int ac,
                            input int br, input int bc);
        op_code = op;
        a_rows  = 3'(ar);
        a_cols  = 3'(ac);
        b_rows  = 3'(br);
        b_cols  = 3'(bc);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Wait for an element, check it, then complete the handshake (out_ready=1).
    task automatic expect_elem(input string tag, input int exp_val, input logic exp_last);
        wait_valid(tag);
        chk(tag, 32'($signed(out_data)), exp_val);
        chk({tag, "_last"}, 32'(out_last), 32'(exp_last));
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        op_code = OP_ADD; a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
        mat_a = '0; mat_b = '0; scalar = '0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(error_flag), 32'd0);
        chk("rst_cnt",   cycle_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD 2x2
        set_a(0,0,1);  set_a(0,1,2);  set_a(1,0,3);  set_a(1,1,4);
        set_b(0,0,10); set_b(0,1,20); set_b(1,0,30); set_b(1,1,40);
        do_start(OP_ADD, 2, 2, 2, 2);
        chk("add_busy", 32'(busy), 32'd1);
        expect_elem("add_e0", 11, 1'b0);
        expect_elem("add_e1", 22, 1'b0);
        expect_elem("add_e2", 33, 1'b0);
        expect_elem("add_e3", 44, 1'b1);
        chk("add_done", 32'(done), 32'd1);
        chk("add_cnt", cycle_cnt, 32'd8);
        tick();
        chk("add_done_off", 32'(done), 32'd0);
        chk("add_idle_busy", 32'(busy), 32'd0);

        // MAT_MUL 2x3 * 3x2
        mat_a = '0; mat_b = '0;
        set_a(0,0,1); set_a(0,1,2); set_a(0,2,3);
        set_a(1,0,4); set_a(1,1,5); set_a(1,2,6);
        set_b(0,0,7);  set_b(0,1,8);
        set_b(1,0,9);  set_b(1,1,10);
        set_b(2,0,11); set_b(2,1,12);
        do_start(OP_MAT_MUL, 2, 3, 3, 2);
        expect_elem("mm_e0", 58, 1'b0);
        expect_elem("mm_e1", 64, 1'b0);
        expect_elem("mm_e2", MM_E2, 1'b0);
        expect_elem("mm_e3", MM_E3, 1'b1);
        chk("mm_done", 32'(done), 32'd1);
        chk("mm_cnt", cycle_cnt, 32'd16);
        tick();
        tick();
        chk("mm_cnt_hold", cycle_cnt, 32'd16);

        // Illegal requests
        do_start(OP_ADD, 2, 2, 3, 2);
        chk("shape_done", 32'(done), 32'd1);
        chk("shape_err", 32'(error_flag), 32'd1);
        chk("shape_valid", 32'(out_valid), 32'd0);
        chk("shape_busy", 32'(busy), 32'd0);
        tick();
        chk("shape_done_off", 32'(done), 32'd0);
        chk("shape_err_hold", 32'(error_flag), 32'd1);
        tick();
        do_start(op_code_t'(3'd6), 2, 2, 2, 2);
        chk("badop_err", 32'(error_flag), 32'd1);
        chk("badop_done", 32'(done), 32'd1);
        tick();
        do_start(OP_TRANSPOSE, 0, 2, 2, 2);
        chk("zerodim_err", 32'(error_flag), 32'd1);
        tick();

        // TRANSPOSE 2x3 with backpressure on the second element
        mat_a = '0;
        set_a(0,0,1); set_a(0,1,2); set_a(0,2,3);
        set_a(1,0,4); set_a(1,1,5); set_a(1,2,6);
        do_start(OP_TRANSPOSE, 2, 3, 1, 1);
        chk("tr_err_clr", 32'(error_flag), 32'd0);
        expect_elem("tr_e0", 1, 1'b0);
        out_ready = 1'b0;
        wait_valid("tr_stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tr_hold_valid", 32'(out_valid), 32'd1);
            chk("tr_hold_data", 32'($signed(out_data)), 32'd4);
        end
        chk("tr_hold_row", 32'(out_row), 32'd0);
        chk("tr_hold_col", 32'(out_col), 32'd1);
        out_ready = 1'b1;
        expect_elem("tr_e1", 4, 1'b0);
        expect_elem("tr_e2", 2, 1'b0);
        expect_elem("tr_e3", 5, 1'b0);
        expect_elem("tr_e4", 3, 1'b0);
        expect_elem("tr_e5", 6, 1'b1);
        chk("tr_done", 32'(done), 32'd1);
        tick();

        // SCALAR_MUL 3x3 of -1 by -128, aborted mid-stream
        mat_a = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                set_a(r, c, -1);
        scalar = 8'h80;
        do_start(OP_SCALAR_MUL, 3, 3, 1, 1);
        expect_elem("sm_e0", SM_E0, 1'b0);
        out_ready = 1'b0;
        wait_valid("sm_e1");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_done2", 32'(done), 32'd0);
        out_ready = 1'b1;

        // abort and start together: nothing starts
        abort = 1'b1;
        do_start(OP_SCALAR_MUL, 3, 3, 1, 1);
        abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        tick();
        chk("abst_busy2", 32'(busy), 32'd0);
        chk("abst_valid", 32'(out_valid), 32'd0);

        // Following operations run normally: ADD 1x1, SUB 1x2
        mat_a = '0; mat_b = '0;
        set_a(0,0,5); set_b(0,0,-7);
        do_start(OP_ADD, 1, 1, 1, 1);
        expect_elem("add1_e0", -2, 1'b1);
        chk("add1_done", 32'(done), 32'd1);
        tick();
        set_a(0,1,-3); set_b(0,0,7); set_b(0,1,100);
        do_start(OP_SUB, 1, 2, 1, 2);
        expect_elem("sub_e0", -2, 1'b0);
        expect_elem("sub_e1", -103, 1'b1);
        tick();

        // Reset asserted mid-CALC
        mat_a = '0; mat_b = '0;
        set_a(0,0,1); set_a(0,1,2); set_a(0,2,3);
        set_b(0,0,7); set_b(1,0,9); set_b(2,0,11);
        do_start(OP_MAT_MUL, 1, 3, 3, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt", cycle_cnt, 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_row", 32'(out_row), 32'd0);
        chk("arst_col", 32'(out_col), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
